// File: rtl/sync_event_arbiter_pkg.sv
// rtl/sync_event_arbiter_pkg.sv - shared types for the event synchroniser/arbiter
package sync_event_arbiter_pkg;

    // HOLDOFF masks edge detection while synchroniser contents are refreshed after reset
    typedef enum logic {
        ST_HOLDOFF = 1'b0,
        ST_RUN     = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sync_event_arbiter_rr_pick.sv
// rtl/sync_event_arbiter_rr_pick.sv - round-robin picker: first request at or after ptr
module rr_pick #(
    parameter  int NEV = 4,
    localparam int IDW = $clog2(NEV)
) (
    input  logic [NEV-1:0] req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    logic [IDW-1:0] idx;

    // scan from the farthest offset down so the nearest request at/after ptr wins
    always_comb begin
        gnt_id = '0;
        any    = |req;
        idx    = '0;
        for (int k = NEV - 1; k >= 0; k--) begin
            idx = IDW'((int'(ptr) + k) % NEV);
            if (req[idx]) begin
                gnt_id = idx;
            end
        end
    end

endmodule

// File: rtl/sync_wire.sv
// rtl/sync_wire.sv - multi-flop synchroniser exposing the last NOUT samples
module sync_wire #(
    parameter int NOUT  = 2,
    parameter int NSYNC = 2
) (
    input  logic            clk,
    input  logic            d,
    output logic [NOUT-1:0] q
);

    localparam int DEPTH = NSYNC + NOUT - 1;

    // q[0] is the newest fully synchronised sample, q[NOUT-1] the oldest
    logic [DEPTH-1:0] chain;

    // plain shift chain; deliberately not reset so it keeps sampling through reset
    always_ff @(posedge clk) begin
        chain <= {chain[DEPTH-2:0], d};
    end

    assign q = chain[DEPTH-1:NSYNC-1];

endmodule

// File: rtl/sync_event_arbiter.sv
// rtl/sync_event_arbiter.sv - synchronise async event strobes and hand them out round-robin
module sync_event_arbiter
    import sync_event_arbiter_pkg::*;
#(
    parameter  int NEV   = 4,
    parameter  int NSYNC = 2,
    parameter  int CW    = 8,
    localparam int IDW   = $clog2(NEV)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NEV-1:0] ev_in,
    output logic           ev_valid,
    output logic [IDW-1:0] ev_id,
    input  logic           ev_ready,
    output logic [NEV-1:0] pending,
    output logic [CW-1:0]  drop_cnt,
    input  logic           drop_clr
);

    localparam int HCW      = $clog2(NSYNC + 1);
    localparam int DROP_MAX = (1 << CW) - 1;

    logic [NEV-1:0] s_new;
    logic [NEV-1:0] s_old;

    for (genvar g = 0; g < NEV; g++) begin : g_sync
        logic [1:0] sq;
        sync_wire #(.NOUT(2), .NSYNC(NSYNC)) u_sync (
            .clk (clk),
            .d   (ev_in[g]),
            .q   (sq)
        );
        assign s_new[g] = sq[0];
        assign s_old[g] = sq[1];
    end

    arb_state_t     state_q;
    arb_state_t     state_d;
    logic [HCW-1:0] hold_cnt_q;
    logic [HCW-1:0] hold_cnt_d;
    logic           run;

    // state register for the post-reset holdoff
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HOLDOFF;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // stay in HOLDOFF for NSYNC+1 cycles so every synchroniser flop is refilled
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        run        = 1'b0;
        case (state_q)
            ST_HOLDOFF: begin
                if (hold_cnt_q == HCW'(NSYNC)) begin
                    state_d    = ST_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = ST_HOLDOFF;
            end
        endcase
    end

    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic           any;

    rr_pick #(.NEV(NEV)) u_pick (
        .req    (pending),
        .ptr    (rr_ptr),
        .gnt_id (gnt_id),
        .any    (any)
    );

    logic           slot_free;
    logic           grant;
    logic [NEV-1:0] gnt_mask;
    logic [NEV-1:0] rise;
    logic [NEV-1:0] drops;
    logic [NEV-1:0] pending_d;
    logic [CW-1:0]  drop_cnt_d;
    logic [IDW-1:0] next_ptr;
    int             ndrop;
    int             drop_sum;

    // edge detect, pending bookkeeping and saturating drop accounting
    always_comb begin
        slot_free = !ev_valid || ev_ready;
        grant     = slot_free && any;
        gnt_mask  = grant ? (NEV'(1) << gnt_id) : '0;
        rise      = s_new & ~s_old & {NEV{run}};
        // a rise coinciding with its own grant re-arms the bit instead of dropping
        drops     = rise & pending & ~gnt_mask;
        pending_d = (pending & ~gnt_mask) | rise;
        ndrop     = 0;
        for (int i = 0; i < NEV; i++) begin
            if (drops[i]) begin
                ndrop = ndrop + 1;
            end
        end
        drop_sum   = (drop_clr ? 0 : int'(drop_cnt)) + ndrop;
        drop_cnt_d = (drop_sum > DROP_MAX) ? CW'(DROP_MAX) : CW'(drop_sum);
        next_ptr   = (gnt_id == IDW'(NEV - 1)) ? '0 : gnt_id + IDW'(1);
    end

    // output slot, pending set, pointer and counter all update on one edge
    always_ff @(posedge clk) begin
        if (reset) begin
            ev_valid <= 1'b0;
            ev_id    <= '0;
            pending  <= '0;
            drop_cnt <= '0;
            rr_ptr   <= '0;
        end else begin
            pending  <= pending_d;
            drop_cnt <= drop_cnt_d;
            if (slot_free) begin
                if (any) begin
                    ev_valid <= 1'b1;
                    ev_id    <= gnt_id;
                    rr_ptr   <= next_ptr;
                end else begin
                    ev_valid <= 1'b0;
                end
            end
        end
    end

endmodule
